// File: rtl/quad_pkg.sv
// Shared types and parameter defaults for the quadrature decoder.
package quad_pkg;

  localparam int unsigned DEF_WIDTH         = 8;
  localparam int unsigned DEF_SYNC_STAGES   = 2;
  localparam int unsigned DEF_FILTER_CYCLES = 4;

  typedef enum logic [1:0] {
    PH_00 = 2'b00,
    PH_01 = 2'b01,
    PH_11 = 2'b11,
    PH_10 = 2'b10
  } phase_t;

endpackage

// File: rtl/quad_input_filter.sv
// One quadrature channel: synchronizer chain followed by a stability filter.
module quad_input_filter
  import quad_pkg::*;
#(
  parameter int unsigned SyncStages   = DEF_SYNC_STAGES,
  parameter int unsigned FilterCycles = DEF_FILTER_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic level,
  output logic valid
);

  localparam int unsigned CntW = 5;
  localparam logic [CntW-1:0] AcceptLast = CntW'(FilterCycles - 1);
  // Start-up also waits out the reset zeros still held in the sync chain.
  localparam logic [CntW-1:0] StartLast  = CntW'(FilterCycles + SyncStages - 1);

  logic [SyncStages-1:0] sync_q;
  logic [CntW-1:0]       cnt_q;
  logic                  sync_out;

  assign sync_out = sync_q[SyncStages-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      level  <= 1'b0;
      valid  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SyncStages-2:0], raw};
      if (!valid) begin
        if (sync_out != level) begin
          level <= sync_out;
          cnt_q <= '0;
        end else if (cnt_q == StartLast) begin
          valid <= 1'b1;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else if (sync_out != level) begin
        if (cnt_q == AcceptLast) begin
          level <= sync_out;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + CntW'(1);
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: filtered A/B phase tracking, up/down count, step and error pulses.
module quadrature_decoder
  import quad_pkg::*;
#(
  parameter int unsigned Width        = DEF_WIDTH,
  parameter int unsigned SyncStages   = DEF_SYNC_STAGES,
  parameter int unsigned FilterCycles = DEF_FILTER_CYCLES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             b_in,
  input  logic             enable,
  input  logic             clear,
  output logic [Width-1:0] count,
  output logic             step,
  output logic             dir,
  output logic             err,
  output logic             err_sticky
);

  logic   a_f, b_f, a_v, b_v;
  logic   ref_q;
  phase_t prev_q, cur;
  logic   is_up, is_dn, is_bad;

  quad_input_filter #(
    .SyncStages  (SyncStages),
    .FilterCycles(FilterCycles)
  ) u_filt_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_in),
    .level(a_f),
    .valid(a_v)
  );

  quad_input_filter #(
    .SyncStages  (SyncStages),
    .FilterCycles(FilterCycles)
  ) u_filt_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_in),
    .level(b_f),
    .valid(b_v)
  );

  assign cur = phase_t'({a_f, b_f});

  always_comb begin
    is_up  = 1'b0;
    is_dn  = 1'b0;
    is_bad = 1'b0;
    case ({prev_q, cur})
      {PH_00, PH_01}, {PH_01, PH_11}, {PH_11, PH_10}, {PH_10, PH_00}: is_up  = 1'b1;
      {PH_00, PH_10}, {PH_10, PH_11}, {PH_11, PH_01}, {PH_01, PH_00}: is_dn  = 1'b1;
      {PH_00, PH_11}, {PH_11, PH_00}, {PH_01, PH_10}, {PH_10, PH_01}: is_bad = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      step       <= 1'b0;
      dir        <= 1'b0;
      err        <= 1'b0;
      err_sticky <= 1'b0;
      prev_q     <= PH_00;
      ref_q      <= 1'b0;
    end else begin
      step <= 1'b0;
      err  <= 1'b0;
      if (a_v && b_v) begin
        prev_q <= cur;
        ref_q  <= 1'b1;
        // First accepted phase only seeds the reference.
        if (ref_q) begin
          if (is_up || is_dn) begin
            step <= 1'b1;
            dir  <= is_up;
            if (enable) count <= is_up ? count + Width'(1) : count - Width'(1);
          end
          if (is_bad) begin
            err        <= 1'b1;
            err_sticky <= 1'b1;
          end
        end
      end
      if (clear) begin
        count      <= '0;
        err_sticky <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench: stimulus predicts events into a queue, a negedge monitor pops and compares.
module tb_quadrature_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       a_in = 1'b0, b_in = 1'b0, enable = 1'b1, clear = 1'b0;
  logic [7:0] count;
  logic       step, dir, err, err_sticky;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit       step;
    bit       err;
    bit       dir;
    bit [7:0] count;
    bit       sticky;
  } ev_t;

  ev_t exp_q[$];

  // Reference model state
  logic [1:0] m_phase;
  int         m_count;
  bit         m_dir, m_sticky;

  quadrature_decoder dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .a_in      (a_in),
    .b_in      (b_in),
    .enable    (enable),
    .clear     (clear),
    .count     (count),
    .step      (step),
    .dir       (dir),
    .err       (err),
    .err_sticky(err_sticky)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && (step || err)) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_event: got step=%0b err=%0b count=%0d, expected no event",
                 step, err, count);
      end else begin
        ev_t e;
        e = exp_q.pop_front();
        if (step !== e.step || err !== e.err || dir !== e.dir || count !== e.count ||
            err_sticky !== e.sticky) begin
          errors++;
          $display("FAIL event: got step=%0b err=%0b dir=%0b count=%0d sticky=%0b, expected step=%0b err=%0b dir=%0b count=%0d sticky=%0b",
                   step, err, dir, count, err_sticky, e.step, e.err, e.dir, e.count, e.sticky);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Position of a phase along the up sequence 00,01,11,10.
  function automatic int gidx(input logic [1:0] p);
    case (p)
      2'b00:   return 0;
      2'b01:   return 1;
      2'b11:   return 2;
      default: return 3;
    endcase
  endfunction

  function automatic void predict(input logic [1:0] ph, input bit clr);
    int  d;
    ev_t e;
    d = (gidx(ph) - gidx(m_phase) + 4) % 4;
    if (d == 1 || d == 3) begin
      m_dir = (d == 1);
      if (enable) m_count = (m_count + (d == 1 ? 1 : 255)) % 256;
    end
    if (d == 2 && !clr) m_sticky = 1'b1;
    if (clr) begin
      m_count  = 0;
      m_sticky = 1'b0;
    end
    if (d != 0) begin
      e.step   = (d != 2);
      e.err    = (d == 2);
      e.dir    = m_dir;
      e.count  = 8'(m_count);
      e.sticky = m_sticky;
      exp_q.push_back(e);
    end
    m_phase = ph;
  endfunction

  task automatic move(input logic [1:0] ph, input int hold, input bit clr);
    @(negedge clk);
    a_in = ph[1];
    b_in = ph[0];
    predict(ph, clr);
    if (clr) begin
      repeat (6) @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
      repeat (hold - 7) @(negedge clk);
    end else begin
      repeat (hold) @(negedge clk);
    end
  endtask

  task automatic do_reset(input logic [1:0] ph);
    @(negedge clk);
    a_in  = ph[1];
    b_in  = ph[0];
    rst_n = 1'b0;
    m_phase  = ph;
    m_count  = 0;
    m_dir    = 1'b0;
    m_sticky = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
  endtask

  task automatic measure_latency(input logic [1:0] ph);
    int lat;
    lat = -1;
    @(negedge clk);
    a_in = ph[1];
    b_in = ph[0];
    predict(ph, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (step && lat < 0) lat = i;
    end
    check("step_latency", lat, 7);
  endtask

  task automatic glitch(input bit chan, input int len);
    @(negedge clk);
    if (chan) a_in = ~a_in; else b_in = ~b_in;
    repeat (len) @(negedge clk);
    if (chan) a_in = ~a_in; else b_in = ~b_in;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    m_phase = 2'b00; m_count = 0; m_dir = 1'b0; m_sticky = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_count", int'(count), 0);
    check("rst_step", int'(step), 0);
    check("rst_dir", int'(dir), 0);
    check("rst_err", int'(err), 0);
    check("rst_sticky", int'(err_sticky), 0);
    do_reset(2'b00);
    check("idle_count", int'(count), 0);

    // Down wrap 0 -> 255, then up wrap 255 -> 0
    move(2'b10, 12, 1'b0);
    move(2'b00, 12, 1'b0);
    // Full up cycle with 10-cycle holds
    move(2'b01, 10, 1'b0);
    move(2'b11, 10, 1'b0);
    move(2'b10, 10, 1'b0);
    move(2'b00, 10, 1'b0);
    check("up_cycle_count", int'(count), 4);
    check("up_cycle_sticky", int'(err_sticky), 0);

    // Short glitch is discarded; a real change lands 7 edges later
    glitch(1'b1, 3);
    check("glitch_count", int'(count), m_count);
    measure_latency(2'b10);

    // Walk to 5 via illegal 00->11, then clear on the next up step
    move(2'b00, 12, 1'b0);
    move(2'b01, 12, 1'b0);
    move(2'b00, 12, 1'b0);
    move(2'b11, 12, 1'b0);
    check("err_sticky_set", int'(err_sticky), 1);
    move(2'b10, 12, 1'b0);
    check("count_before_clear", int'(count), 5);
    move(2'b00, 12, 1'b1);
    check("clear_count", int'(count), 0);

    // Steps with enable low must not move count
    enable = 1'b0;
    move(2'b01, 10, 1'b0);
    move(2'b11, 10, 1'b0);
    move(2'b10, 10, 1'b0);
    move(2'b00, 10, 1'b0);
    check("enable_low_count", int'(count), 0);
    enable = 1'b1;

    // Random walk
    for (int n = 0; n < 80; n++) begin
      int r;
      logic [1:0] seq [4];
      int idx;
      seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b11; seq[3] = 2'b10;
      idx = gidx(m_phase);
      r = int'($urandom_range(0, 9));
      if (r <= 3)      move(seq[(idx + 1) % 4], int'($urandom_range(10, 20)), 1'b0);
      else if (r <= 6) move(seq[(idx + 3) % 4], int'($urandom_range(10, 20)), 1'b0);
      else if (r == 7) move(seq[(idx + 2) % 4], int'($urandom_range(10, 20)), 1'b0);
      else if (r == 8) glitch(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      else begin
        @(negedge clk);
        enable = ~enable;
      end
    end
    enable = 1'b1;
    repeat (12) @(negedge clk);
    check("random_count", int'(count), m_count);

    // Reset released with both channels high: reference only
    do_reset(2'b11);
    repeat (10) @(negedge clk);
    check("rst11_count", int'(count), 0);
    check("rst11_sticky", int'(err_sticky), 0);
    move(2'b10, 12, 1'b0);
    check("rst11_step_count", int'(count), 1);

    repeat (20) @(negedge clk);
    check("pending_events", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/quadrature_decoder.md
QUADRATURE_DECODER -- requirements
Module: quadrature_decoder

Interface
REQ-001 Parameter Width, default 8: bit width of count.
REQ-002 Parameter SyncStages, default 2: synchronizer flops per channel; legal range 2..4.
REQ-003 Parameter FilterCycles, default 4: consecutive stable cycles needed to accept a new input level; legal range 1..15.
REQ-004 clk  input  1  sole clock; all state updates on posedge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 a_in  input  1  quadrature channel A, asynchronous to clk.
REQ-007 b_in  input  1  quadrature channel B, asynchronous to clk.
REQ-008 enable  input  1  when high, decoded steps update count.
REQ-009 clear  input  1  synchronous clear of count and err_sticky.
REQ-010 count  output  Width  position, unsigned, modulo 2^Width.
REQ-011 step  output  1  one-cycle pulse per accepted legal transition.
REQ-012 dir  output  1  direction of last step: 1 = up, 0 = down.
REQ-013 err  output  1  one-cycle pulse on an illegal transition.
REQ-014 err_sticky  output  1  latched error flag.

Function
REQ-015 Each channel SHALL pass through a SyncStages-deep flop chain before any other use.
REQ-016 The filtered level SHALL take the synchronized value only after that value has differed from the filtered level for FilterCycles consecutive cycles; any shorter excursion SHALL be discarded and SHALL restart the stability count.
REQ-017 Phase = {A_f, B_f}; up sequence 00->01->11->10->00; down sequence is the reverse.
REQ-018 Up transition: step=1, dir=1, count+1, wrapping 2^Width-1 -> 0.
REQ-019 Down transition: step=1, dir=0, count-1, wrapping 0 -> 2^Width-1.
REQ-020 Both filtered bits changing on the same cycle: err=1, err_sticky=1, step=0; count and dir unchanged; new phase adopted as reference.
REQ-021 step, dir, err and count SHALL update on the clock edge after the filtered phase changes; total latency from the first edge sampling a new stable input level to step = SyncStages+FilterCycles+1 edges (7 with defaults).
REQ-022 enable=0: phase tracking and err/err_sticky continue; step pulses still issue and dir still updates; count holds.
REQ-023 clear=1: count<=0 and err_sticky<=0 on that edge, overriding any step in that same cycle; the step pulse is still emitted; an err occurring in the same cycle still pulses err but SHALL NOT set err_sticky.
REQ-024 First filtered phase accepted after reset SHALL be loaded as reference only: no step and no err.

Reset
REQ-025 rst_n low SHALL immediately force count=0, step=0, dir=0, err=0, err_sticky=0, synchronizers=0, filter counts=0, and reference invalid.
REQ-026 Reset asserted mid-count SHALL discard in-progress filter counts; after release, behaviour SHALL be as from power-up (REQ-024).

Structure
REQ-027 Package quad_pkg SHALL hold typedef enum phase_t {PH_00, PH_01, PH_11, PH_10} and the parameter defaults.
REQ-028 Sub-module quad_input_filter (synchronizer plus stability filter, one channel) SHALL be instantiated once per channel.
REQ-029 Transition decode SHALL be a single case on {previous phase, current phase}; no latches; outputs registered.

Verification (defaults, Width=8)
REQ-030 Reset, then hold A=B=0, then one full up cycle 00->01->11->10->00 with each level held 10 cycles -> four step pulses, dir=1, count=4, err never set.
REQ-031 From count=0, one down step -> count=255, dir=0; from count=255, one up step -> count=0.
REQ-032 3-cycle glitch on a_in -> no step, count unchanged; a 4-cycle-stable change -> step exactly 7 edges after the first sampled edge.
REQ-033 Toggle A and B on the same cycle (00->11) -> err pulse, err_sticky=1, count unchanged; following legal step counts from 11.
REQ-034 clear asserted on the same cycle as an up step at count=5 -> count=0, err_sticky=0, step pulses; enable=0 during four up steps -> count holds, four step pulses.
REQ-035 Release reset with A=B=1 held -> no step, no err; subsequent 11->10 -> count=1.
